// File: rtl/normalise_shift.sv
// normalise_shift: two-stage streaming leading-zero normaliser.
// Stage 1 captures the word with its leading-zero count and zero flag,
// stage 2 produces the left-justified mantissa. Both ends use valid/ready
// handshakes and the pipeline sustains one word per cycle.
// Optional feature macro: NORM_COUNT_EN adds a saturating 16-bit counter
// of accepted words on out_count.
module normalise_shift #(
  parameter int W_IN  = 8,
  parameter int W_OUT = $clog2(W_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_IN-1:0]  out_mant,
  output logic [W_OUT-1:0] out_shift,
  output logic             out_zero
`ifdef NORM_COUNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  logic             s1_valid;
  logic [W_IN-1:0]  s1_data;
  logic             s1_zero;
  logic [W_OUT-1:0] s1_clz;
  logic             s1_adv;
  logic             s2_adv;

  // Leading-zero count; an all-zero word yields all-ones, which the
  // output stage replaces with a zero shift.
  function automatic logic [W_OUT-1:0] count_lead_zero(input logic [W_IN-1:0] d);
    logic [W_OUT-1:0] n;
    logic             found;
    n     = '1;
    found = 1'b0;
    for (int i = W_IN - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        n     = W_OUT'(W_IN - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Each stage advances when it is empty or its contents are leaving, so
  // bubbles collapse; in_ready depends only on register state and out_ready.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: capture the incoming word, its zero flag and its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_zero  <= 1'b0;
      s1_clz   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_zero <= ~|in_data;
        s1_clz  <= count_lead_zero(in_data);
      end
    end
  end

  // Stage 2: left-justify the word; zero words report shift 0 and mantissa 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant  <= s1_zero ? '0 : (s1_data << s1_clz);
        out_shift <= s1_zero ? '0 : s1_clz;
        out_zero  <= s1_zero;
      end
    end
  end

`ifdef NORM_COUNT_EN
  // Count accepted words, sticking at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= 16'd0;
    end else if (in_valid && in_ready && (out_count != 16'hFFFF)) begin
      out_count <= out_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_normalise_shift.sv
// tb_normalise_shift: randomized and directed bench for normalise_shift.
// A queue of in-flight words, each tagged with the edge at which it may
// first appear on the output, models the pipeline; expected results are
// computed arithmetically from the input value.
// Define NORM_COUNT_EN to also exercise the saturating word counter.
module tb_normalise_shift;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mant;
  logic [2:0] out_shift;
  logic       out_zero;
`ifdef NORM_COUNT_EN
  logic [15:0] out_count;
`endif

  typedef struct {
    int mant;
    int shift;
    int zero;
    int ready_edge;
  } item_t;

  item_t q[$];
  int    checks;
  int    errors;
  int    edges;
  int    accepted;

  normalise_shift #(.W_IN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_shift (out_shift),
    .out_zero  (out_zero)
`ifdef NORM_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of doublings needed to bring a nonzero byte up to >= 128.
  function automatic int ref_shift(input int x);
    int s;
    s = 0;
    if (x == 0) return 0;
    while (x < 128) begin
      x = x * 2;
      s++;
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, check the visible state
  // against the model, update the model, and advance to the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    logic  exp_ready;
    logic  exp_valid;
    item_t it;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    exp_ready = (q.size() < 2) || r;
    exp_valid = (q.size() > 0) && (edges >= q[0].ready_edge);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("out_mant", 32'(out_mant), 32'(q[0].mant));
      checkOutput("out_shift", 32'(out_shift), 32'(q[0].shift));
      checkOutput("out_zero", 32'(out_zero), 32'(q[0].zero));
      if (r) void'(q.pop_front());
    end
`ifdef NORM_COUNT_EN
    checkOutput("out_count", 32'(out_count), (accepted > 65535) ? 32'hFFFF : 32'(accepted));
`endif
    if (v && exp_ready) begin
      it.shift      = ref_shift(int'(d));
      it.mant       = (int'(d) << it.shift) % 256;
      it.zero       = (d == 8'd0) ? 1 : 0;
      it.ready_edge = edges + 2;
      q.push_back(it);
      accepted++;
    end
    @(negedge clk);
    edges++;
  endtask

  initial begin
    logic [7:0] rd;
    checks    = 0;
    errors    = 0;
    edges     = 0;
    accepted  = 0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    rst_n     = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_mant", 32'(out_mant), 32'd0);
    checkOutput("rst_out_shift", 32'(out_shift), 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
`ifdef NORM_COUNT_EN
    checkOutput("rst_out_count", 32'(out_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // First word 0x16 then a few idle cycles
    applyStimulus(1'b1, 8'h16, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("first_mant", 32'(out_mant), 32'hB0);
    checkOutput("first_shift", 32'(out_shift), 32'd3);
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Zero word and the shift extremes
    applyStimulus(1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h80, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

    // Back-to-back walking one
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(1 << i), 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

    // Fill both stages, stall for five cycles with input pending, release
    applyStimulus(1'b1, 8'h05, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    repeat (5) applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd >> $urandom_range(0, 7);
      if ($urandom_range(0, 15) == 0) rd = 8'h00;
      applyStimulus($urandom_range(0, 3) != 0, rd, $urandom_range(0, 2) != 0);
    end
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Reset while both stages hold data
    applyStimulus(1'b1, 8'h21, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0);
    #1;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("async_rst_mant", 32'(out_mant), 32'd0);
`ifdef NORM_COUNT_EN
    checkOutput("async_rst_count", 32'(out_count), 32'd0);
`endif
    q.delete();
    accepted = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h09, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

`ifdef NORM_COUNT_EN
    // Drive enough words to saturate the counter
    for (int i = 0; i < 70000; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("count_saturated", 32'(out_count), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
